mem_access_ctrl: RTL and testbench

// - Memory-stage access controller between the pipeline's M stage (aluoutM/writedataM in, readdataM out) and a

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Single-port data bus between the memory-stage controller (master) and the data memory (slave).
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage load/store controller: req/ack bus master with lane steering, load extension and timeout abort.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses instead of forcing them aligned.
module mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [2:0]        memop,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_out,
  output logic              stall_mem,
  mem_access_ctrl_if.master bus,
  output logic              bus_err,
  output logic              addr_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} memop_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  memop_e      op, op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_byte, is_half, is_store, reject;
  logic [1:0]  lane;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  assign op = memop_e'(memop);

  // Access decode; misaligned half/word lanes are forced down to the natural boundary.
  always_comb begin
    is_byte  = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    if (is_byte) begin
      lane      = addr[1:0];
      be_new    = 4'b0001 << addr[1:0];
      wdata_new = {4{wdata[7:0]}};
    end else if (is_half) begin
      lane      = {addr[1], 1'b0};
      be_new    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{wdata[15:0]}};
    end else begin
      lane      = 2'b00;
      be_new    = 4'b1111;
      wdata_new = wdata;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic aerr_q;
  assign reject = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));
  always_ff @(posedge clk) begin
    if (rst) aerr_q <= 1'b0;
    else     aerr_q <= (state_q == S_IDLE) && mem_en && reject;
  end
  assign addr_err = aerr_q;
`else
  assign reject   = 1'b0;
  assign addr_err = 1'b0;
`endif

  function automatic logic [31:0] extend_load(memop_e ld, logic [1:0] ln, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{ln, 3'b000} +: 8];
    h = ln[1] ? d[31:16] : d[15:0];
    case (ld)
      OP_LB:   extend_load = {{24{b[7]}}, b};
      OP_LBU:  extend_load = {24'h0, b};
      OP_LH:   extend_load = {{16{h[15]}}, h};
      OP_LHU:  extend_load = {16'h0, h};
      default: extend_load = d;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    stall_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en && reject) begin
          rdata_d = '0;
        end else if (mem_en) begin
          stall_mem = 1'b1;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {addr[31:2], 2'b00};
          be_d      = be_new;
          wdata_d   = wdata_new;
          lane_d    = lane;
          op_d      = op;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_mem = 1'b1;
        // Ack has priority over a timeout expiring in the same cycle.
        if (bus.bus_ack) begin
          req_d   = 1'b0;
          rdata_d = extend_load(op_q, lane_q, bus.bus_rdata);
          state_d = S_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LB;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign rdata_out     = rdata_q;
  assign bus_err       = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: main instance MAX_WAIT=5, timeout instance MAX_WAIT=4.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_en_t = 1'b0;
  logic [2:0]  memop = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_out, rdata_t;
  logic        stall_mem, stall_t, bus_err, bus_err_t, addr_err, addr_err_t;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_access_ctrl_if bus();
  mem_access_ctrl_if bus_t();

  mem_access_ctrl #(.MAX_WAIT(5)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .memop(memop), .addr(addr), .wdata(wdata),
    .rdata_out(rdata_out), .stall_mem(stall_mem), .bus(bus), .bus_err(bus_err), .addr_err(addr_err)
  );

  mem_access_ctrl #(.MAX_WAIT(4)) dut_t (
    .clk(clk), .rst(rst), .mem_en(mem_en_t), .memop(memop), .addr(addr), .wdata(wdata),
    .rdata_out(rdata_t), .stall_mem(stall_t), .bus(bus_t), .bus_err(bus_err_t), .addr_err(addr_err_t)
  );

  always #5 clk = ~clk;

  // Drives one access from IDLE; ack_at = req cycle (1-based) carrying the ack, 0 = never.
  // Returns in the DONE cycle (or in IDLE if the access was rejected) with mem_en dropped.
  task automatic run_access(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rd, output int stalls, output int reqs);
    logic st, rq;
    stalls = 0;
    reqs   = 0;
    memop  = op;
    addr   = a;
    wdata  = wd;
    if (sel) mem_en_t = 1'b1;
    else     mem_en   = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      st = sel ? stall_t : stall_mem;
      rq = sel ? bus_t.bus_req : bus.bus_req;
      if (!st) break;
      stalls++;
      if (rq) reqs++;
      if (sel) begin
        bus_t.bus_ack = rq && (reqs == ack_at);
        bus_t.bus_rdata = rd;
      end else begin
        bus.bus_ack = rq && (reqs == ack_at);
        bus.bus_rdata = rd;
      end
      @(posedge clk); #1;
      bus.bus_ack   = 1'b0;
      bus_t.bus_ack = 1'b0;
    end
    mem_en   = 1'b0;
    mem_en_t = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall_mem); end
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", bus.bus_req); end
    n_chk++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", rdata_out); end
    n_chk++; if ({bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata} !== 69'h0) begin
      n_fail++; $display("FAIL reset_bus: we=%b be=%b addr=%h wdata=%h exp all 0",
                         bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata);
    end
    n_chk++; if ({bus_err, addr_err, bus_err_t} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err: got %b exp 000", {bus_err, addr_err, bus_err_t});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int st, rq;
    run_access(1'b0, 3'd4, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, st, rq);
    n_chk++; if (st != 2) begin n_fail++; $display("FAIL lw_stall: got %0d exp 2", st); end
    n_chk++; if (bus.bus_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b exp 1111", bus.bus_be); end
    n_chk++; if (bus.bus_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h exp 100", bus.bus_addr); end
    n_chk++; if (bus.bus_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b exp 0", bus.bus_we); end
    n_chk++; if (rdata_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h exp deadbeef", rdata_out); end
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %b exp 0", bus.bus_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    int st, rq;
    run_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 1, 32'h8012_3456, st, rq);
    n_chk++; if (bus.bus_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", bus.bus_be); end
    n_chk++; if (rdata_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h exp ffffff80", rdata_out); end
    @(posedge clk); #1;
    run_access(1'b0, 3'd1, 32'h0000_0103, 32'h0, 1, 32'h8012_3456, st, rq);
    n_chk++; if (rdata_out !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h exp 00000080", rdata_out); end
    @(posedge clk); #1;
    run_access(1'b0, 3'd2, 32'h0000_0102, 32'h0, 1, 32'h8001_1234, st, rq);
    n_chk++; if (bus.bus_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be: got %b exp 1100", bus.bus_be); end
    n_chk++; if (rdata_out !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata: got %h exp ffff8001", rdata_out); end
    @(posedge clk); #1;
    run_access(1'b0, 3'd3, 32'h0000_0100, 32'h0, 1, 32'h1234_F00D, st, rq);
    n_chk++; if (bus.bus_be !== 4'b0011) begin n_fail++; $display("FAIL lhu_be: got %b exp 0011", bus.bus_be); end
    n_chk++; if (rdata_out !== 32'h0000_F00D) begin n_fail++; $display("FAIL lhu_rdata: got %h exp 0000f00d", rdata_out); end
    @(posedge clk); #1;
  endtask

  // SH ack lands in the 5th req cycle, the same cycle the MAX_WAIT=5 timeout would fire.
  task automatic test_stores();
    int st, rq;
    run_access(1'b0, 3'd6, 32'h0000_0102, 32'h1234_ABCD, 5, 32'h0, st, rq);
    n_chk++; if (st != 6) begin n_fail++; $display("FAIL sh_stall: got %0d exp 6", st); end
    n_chk++; if (rq != 5) begin n_fail++; $display("FAIL sh_req_cycles: got %0d exp 5", rq); end
    n_chk++; if (bus.bus_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b exp 1100", bus.bus_be); end
    n_chk++; if (bus.bus_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h exp abcdabcd", bus.bus_wdata); end
    n_chk++; if (bus.bus_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b exp 1", bus.bus_we); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL sh_ack_wins: bus_err got %b exp 0", bus_err); end
    @(posedge clk); #1;
    run_access(1'b0, 3'd5, 32'h0000_0101, 32'hFFFF_FFA5, 2, 32'h0, st, rq);
    n_chk++; if (st != 3) begin n_fail++; $display("FAIL sb_stall: got %0d exp 3", st); end
    n_chk++; if (bus.bus_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b exp 0010", bus.bus_be); end
    n_chk++; if (bus.bus_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", bus.bus_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int st, rq;
    run_access(1'b1, 3'd4, 32'h0000_0200, 32'h0, 1, 32'h5A5A_5A5A, st, rq);
    n_chk++; if (rdata_t !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL to_preload: got %h exp 5a5a5a5a", rdata_t); end
    @(posedge clk); #1;
    run_access(1'b1, 3'd4, 32'h0000_0200, 32'h0, 0, 32'h0, st, rq);
    n_chk++; if (rq != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d exp 4", rq); end
    n_chk++; if (st != 5) begin n_fail++; $display("FAIL to_stall: got %0d exp 5", st); end
    n_chk++; if (bus_err_t !== 1'b1) begin n_fail++; $display("FAIL to_err_pulse: got %b exp 1", bus_err_t); end
    n_chk++; if (rdata_t !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h exp 0", rdata_t); end
    bus_t.bus_ack   = 1'b1;
    bus_t.bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_t.bus_ack = 1'b0;
    n_chk++; if (bus_err_t !== 1'b0) begin n_fail++; $display("FAIL to_err_once: got %b exp 0", bus_err_t); end
    n_chk++; if (rdata_t !== 32'h0) begin n_fail++; $display("FAIL to_late_ack: got %h exp 0", rdata_t); end
    n_chk++; if ({bus_t.bus_req, stall_t} !== 2'b00) begin
      n_fail++; $display("FAIL to_idle: req/stall got %b exp 00", {bus_t.bus_req, stall_t});
    end
  endtask

  task automatic test_misaligned();
    int st, rq;
    run_access(1'b0, 3'd4, 32'h0000_0102, 32'h0, 1, 32'hCAFE_F00D, st, rq);
`ifdef MEM_ALIGN_CHECK_EN
    n_chk++; if (st != 0) begin n_fail++; $display("FAIL mis_stall: got %0d exp 0", st); end
    @(posedge clk); #1;
    n_chk++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL mis_addr_err: got %b exp 1", addr_err); end
    n_chk++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h exp 0", rdata_out); end
    n_chk++; if (rq != 0 || bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %0d/%b exp 0/0", rq, bus.bus_req); end
    @(posedge clk); #1;
    n_chk++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_once: got %b exp 0", addr_err); end
`else
    n_chk++; if (st != 2) begin n_fail++; $display("FAIL mis_stall: got %0d exp 2", st); end
    n_chk++; if (bus.bus_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h exp 100", bus.bus_addr); end
    n_chk++; if (bus.bus_be !== 4'b1111) begin n_fail++; $display("FAIL mis_be: got %b exp 1111", bus.bus_be); end
    n_chk++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL mis_addr_err: got %b exp 0", addr_err); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    memop  = 3'd4;
    addr   = 32'h0000_0300;
    mem_en = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_up: got %b exp 1", bus.bus_req); end
    @(posedge clk); #1;
    rst    = 1'b1;
    mem_en = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({bus.bus_req, stall_mem} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_abort: req/stall got %b exp 00", {bus.bus_req, stall_mem});
    end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b exp 0", bus_err); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({bus.bus_req, stall_mem, bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_after: req/stall/err got %b exp 000", {bus.bus_req, stall_mem, bus_err});
    end
  endtask

  initial begin
    bus.bus_ack     = 1'b0;
    bus.bus_rdata   = 32'h0;
    bus_t.bus_ack   = 1'b0;
    bus_t.bus_rdata = 32'h0;
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
